dmem_wait_model: RTL
====================

# dmem_wait_model

Parametrised byte-addressed data memory with programmable wait states and error response. It serves the core's data port (`req_mem`/`wmem_o`/`wmask`/`addr_o`/`data_o` → `data_i`/`data_stall`/`data_err`) in core-level benches and FPGA bring-up. It generalises the flat zero-latency bench memory with the following additions:

- configurable size and base address
- fixed or pseudo-random stall insertion
- out-of-range error signalling

## Interface
- `DEPTH_BYTES`, 4096: memory size in bytes; power of two, ≥ 4.
- `BASE_ADDR`, 32'h0: byte address mapped to location 0.
- `STALL_MODE`, 0: 0 = fixed `WAIT_STATES` per request; 1 = LFSR-random 0..`MAX_WAIT`.
- `WAIT_STATES`, 0: stall cycles per request in mode 0; range 0..15.
- `MAX_WAIT`, 3: upper bound of the random wait in mode 1; range 0..15.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_mem` in 1: access request; held until the response cycle.
- `wmem` in 1: 1 = write, 0 = read.
- `wmask` in 4: byte enables for writes; ignored on reads.
- `addr` in 32: byte address; any alignment.
- `wdata` in 32: write data; byte k = `wdata[8k+7:8k]`.
- `rdata` out 32: read data, little-endian: `{mem[a+3],mem[a+2],mem[a+1],mem[a]}`.
- `data_stall` out 1: 1 = response not ready; the master must hold all inputs.
- `data_err` out 1: response-cycle error; the accessed window is out of range.

## Operation
- Reset (`reset`=0):
  - memory byte i ← i[7:0]
  - state IDLE, `cnt` ← 0, LFSR ← `LFSR_SEED`
  - outputs: `data_stall`=0, `data_err`=0, `rdata`=0
- Offset: off = `addr` − `BASE_ADDR` (32-bit, wrapping).
- Range check: the access is in range iff off ≤ `DEPTH_BYTES`−4, i.e. all four bytes lie in the array. There is no wrap inside the array.
- Wait value w, sampled in IDLE when `req_mem`=1:
  - mode 0: w = `WAIT_STATES`
  - mode 1: w = LFSR[3:0] mod (`MAX_WAIT`+1); the LFSR advances one step on each such sample.
- FSM states are IDLE and WAIT.
  - IDLE, `req_mem`=0: stall=0, err=0, `rdata`=0.
  - IDLE, `req_mem`=1, w=0: response cycle (see below); remain IDLE.
  - IDLE, `req_mem`=1, w>0: stall=1, `cnt` ← w−1, go to WAIT.
  - WAIT, `cnt`≠0: stall=1, `cnt` ← `cnt`−1.
  - WAIT, `cnt`=0: response cycle; go to IDLE.
  - WAIT, `req_mem` drops early: this is a protocol violation. Go to IDLE, `cnt` ← 0, no write.
- Response cycle behaviour:
  - `data_stall`=0.
  - In range: `rdata` = the four bytes at off..off+3. A write commits the enabled bytes at the closing edge.
  - Out of range: `data_err`=1, `rdata`=0, no write.
- Read data is taken combinationally from the array. It reflects writes committed at earlier edges, never the write of the current cycle.
- Consecutive requests: after a response, a request in the next cycle samples a fresh w. There are no idle bubbles imposed.

## Timing
- `data_stall`, `data_err` and `rdata` are combinational from state, `cnt`, `req_mem` and `addr`; there is no registered output delay.
- A request with wait w has exactly w stall cycles, then the response in cycle w (counting from 0).
- Write latency: contents update at the edge closing the response cycle.
- Asynchronous reset mid-WAIT: an in-flight write is discarded. `data_stall` drops immediately while `reset`=0.
- After `reset` deasserts, the first request is sampled at the first rising edge.

## Structure
- `dmem_pkg` holds:
  - `dmem_state_e` {IDLE, WAIT}
  - the LFSR tap constant (x^16+x^14+x^13+x^11+1)
  - the 4-bit wait width constant
- Sub-module `lfsr16` has ports `clk`, `reset`, `en`, `seed` → `q[15:0]`, with Fibonacci taps from the package.
- The top holds the byte array, FSM, counter and range logic.

## Test plan
- Reset, mode 0, `WAIT_STATES`=0, read `addr`=0 → `rdata`=32'h03020100, no stall; read `addr`=0x0FFC → 32'hFFFEFDFC.
- Write `addr`=0x10, `wdata`=32'hDEADBEEF, `wmask`=4'b0101, then read 0x10 → 32'h13AD11EF.
- `WAIT_STATES`=3, single read → `data_stall` high for exactly 3 cycles, low in the 4th with valid `rdata`. Back-to-back requests → 3 stall cycles each.
- `BASE_ADDR`=32'h1000:
  - read 0x0FFF → `data_err`=1, `rdata`=0
  - read 0x1FFD → `data_err`=1
  - write to 0x2000 → array unchanged
- `WAIT_STATES`=2, write issued, `reset` pulsed low in the first stall cycle → target bytes keep their reset pattern; next read is correct after 2 stalls.
- Mode 1, `MAX_WAIT`=3, 200 random reads:
  - every stall run is ≤ 3
  - runs of 0, 1, 2 and 3 all occur
  - the sequence repeats identically with the same `LFSR_SEED`

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data memory model.
package dmem_pkg;

  // Two-state handshake FSM: idle/response, or counting down stall cycles.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_e;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Width of the wait counter; wait values range 0..15.
  localparam int WAIT_W = 4;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used to pick pseudo-random wait values.
module lfsr16
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic fb;

  // Feedback is the XOR of all tapped bits, shifted in at the bottom.
  assign fb = ^(q & LFSR_TAPS);

  // Load the seed on reset, otherwise advance one step whenever enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= seed;
    end else if (en) begin
      q <= {q[14:0], fb};
    end
  end

endmodule

// File: rtl/dmem_wait_model.sv
// Byte-addressed data memory with fixed or pseudo-random wait states and
// an error response for accesses whose 4-byte window leaves the array.
module dmem_wait_model
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned STALL_MODE  = 0,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned MAX_WAIT    = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_mem,
  input  logic        wmem,
  input  logic [3:0]  wmask,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        data_stall,
  output logic        data_err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam logic [31:0] LAST_OFF = 32'(DEPTH_BYTES - 4);
  localparam logic [WAIT_W-1:0] FIXED_W = WAIT_W'(WAIT_STATES);
  localparam logic [31:0] RAND_MOD = 32'(MAX_WAIT + 1);

  dmem_state_e state, state_next;
  logic [WAIT_W-1:0] cnt, cnt_next, w;
  logic [15:0] lfsr_q;
  logic [31:0] rnd_ext;
  logic lfsr_en;
  logic lfsr_unused;
  logic [31:0] off;
  logic in_range;
  logic [AW-1:0] idx [4];
  logic stall, resp, resp_ok, do_write;
  logic [7:0] mem [DEPTH_BYTES];

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // Only the low bits of the LFSR feed the wait value.
  assign lfsr_unused = ^lfsr_q[15:WAIT_W];
  assign rnd_ext = 32'(lfsr_q[WAIT_W-1:0]);

  // The window is in range only when all four bytes fit; no wrap inside the array.
  assign off = addr - BASE_ADDR;
  assign in_range = (off <= LAST_OFF);

  // Byte lane k of the access maps to array location off+k.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k] = off[AW-1:0] + AW'(k);
    end
  end

  // Wait value for a newly sampled request: fixed, or LFSR-derived.
  always_comb begin
    w = FIXED_W;
    if (STALL_MODE != 0) begin
      w = WAIT_W'(rnd_ext % RAND_MOD);
    end
  end

  // State and wait counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; a dropped request in WAIT abandons the access.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    resp       = 1'b0;
    lfsr_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_mem) begin
          lfsr_en = (STALL_MODE != 0);
          if (w == '0) begin
            resp = 1'b1;
          end else begin
            stall      = 1'b1;
            cnt_next   = w - WAIT_W'(1);
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req_mem) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt != '0) begin
          stall    = 1'b1;
          cnt_next = cnt - WAIT_W'(1);
        end else begin
          resp       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are combinational and forced quiet while reset is held low.
  always_comb begin
    resp_ok    = resp & reset;
    data_stall = stall & reset;
    data_err   = resp_ok & ~in_range;
    do_write   = resp_ok & in_range & wmem;
    rdata      = '0;
    if (resp_ok && in_range) begin
      rdata = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};
    end
  end

  // Byte array: reset to an address pattern, enabled bytes committed at the response edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH_BYTES); i++) begin
        mem[i] <= 8'(i);
      end
    end else if (do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) begin
          mem[idx[k]] <= wdata[8*k +: 8];
        end
      end
    end
  end

endmodule
